// File: rtl/rgb_to_bayer_mosaic.sv
// Streaming re-mosaic: full-RGB pixels in, single-channel Bayer RAW out with {Y,X} phase bits.
// Optional sticky line-length checker is built when LINE_CHECK_EN is defined.
module rgb_to_bayer_mosaic #(
  parameter int DW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int X_INIT   = 0,
  parameter int Y_INIT   = 0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic          in_eol,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] in_g,
  input  logic [DW-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_raw,
  output logic          out_x,
  output logic          out_y,
  output logic          out_sof,
  output logic          out_eol,
  output logic          frame_done,
  output logic          err_line
);

  localparam int CW = $clog2(H_ACTIVE) + 1;
  localparam int RW = $clog2(V_ACTIVE) + 1;
  localparam logic [0:0]    WAIT_SOF = 1'b0;
  localparam logic [0:0]    ACTIVE   = 1'b1;
  localparam logic [CW-1:0] COL_MAX  = {CW{1'b1}};
  localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);
  localparam logic          X0       = 1'(X_INIT);
  localparam logic          Y0       = 1'(Y_INIT);

  logic [0:0]    state_r, state_nxt_s;
  logic [CW-1:0] col_r, col_nxt_s, col_cur_s;
  logic [RW-1:0] row_r, row_nxt_s, row_cur_s;
  logic          accept_s, emit_s, last_s;
  logic          x_s, y_s;
  logic [DW-1:0] raw_s;

  assign in_ready  = !out_valid | out_ready;
  assign accept_s  = in_valid & in_ready;
  // An sof pixel restarts the frame from any state, so it always sits at col 0 / row 0.
  assign emit_s    = accept_s & (in_sof | (state_r == ACTIVE));
  assign col_cur_s = in_sof ? {CW{1'b0}} : col_r;
  assign row_cur_s = in_sof ? {RW{1'b0}} : row_r;
  assign x_s       = X0 ^ col_cur_s[0];
  assign y_s       = Y0 ^ row_cur_s[0];

  // Bayer site select: pure routing of one colour channel.
  always_comb begin
    case ({y_s, x_s})
      2'b00:   raw_s = in_r;
      2'b11:   raw_s = in_b;
      2'b01:   raw_s = in_g;
      2'b10:   raw_s = in_g;
      default: raw_s = in_g;
    endcase
  end

  // Raster position and frame state for the next pixel.
  always_comb begin
    state_nxt_s = state_r;
    col_nxt_s   = col_r;
    row_nxt_s   = row_r;
    last_s      = 1'b0;
    if (emit_s) begin
      if (in_eol) begin
        col_nxt_s = {CW{1'b0}};
        if (row_cur_s == ROW_LAST) begin
          last_s      = 1'b1;
          row_nxt_s   = {RW{1'b0}};
          state_nxt_s = WAIT_SOF;
        end else begin
          row_nxt_s   = row_cur_s + 1'b1;
          state_nxt_s = ACTIVE;
        end
      end else begin
        col_nxt_s   = (col_cur_s == COL_MAX) ? COL_MAX : col_cur_s + 1'b1;
        row_nxt_s   = row_cur_s;
        state_nxt_s = ACTIVE;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, position and the single output register stage.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r    <= WAIT_SOF;
      col_r      <= {CW{1'b0}};
      row_r      <= {RW{1'b0}};
      out_valid  <= 1'b0;
      out_raw    <= {DW{1'b0}};
      out_x      <= 1'b0;
      out_y      <= 1'b0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      col_r      <= col_nxt_s;
      row_r      <= row_nxt_s;
      frame_done <= last_s;
      if (emit_s) begin
        out_valid <= 1'b1;
        out_raw   <= raw_s;
        out_x     <= x_s;
        out_y     <= y_s;
        out_sof   <= in_sof;
        out_eol   <= in_eol;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

`ifdef LINE_CHECK_EN
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
  logic line_bad_s;

  assign line_bad_s = emit_s & (in_eol ? (col_cur_s != COL_LAST) : (col_cur_s == COL_LAST));

  // Sticky line-length error; a new frame clears it unless its first pixel is already bad.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      err_line <= 1'b0;
    end else if (emit_s & in_sof) begin
      err_line <= line_bad_s;
    end else if (line_bad_s) begin
      err_line <= 1'b1;
    end else begin
      err_line <= err_line;
    end
  end
`else
  assign err_line = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_to_bayer_mosaic.sv
// Bench for rgb_to_bayer_mosaic: two instances (X_INIT=0 and X_INIT=1) against a raster-position model.
module tb_rgb_to_bayer_mosaic;
  localparam int DW   = 10;
  localparam int H    = 4;
  localparam int V    = 2;
  localparam int CMAX = 7;

  logic CLK = 1'b0, RST_N = 1'b0;
  logic in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_r = '0, in_g = '0, in_b = '0;

  logic in_ready1, out_valid1, out_x1, out_y1, out_sof1, out_eol1, frame_done1, err_line1;
  logic in_ready2, out_valid2, out_x2, out_y2, out_sof2, out_eol2, frame_done2, err_line2;
  logic [DW-1:0] out_raw1, out_raw2;

  rgb_to_bayer_mosaic #(.DW(DW), .H_ACTIVE(H), .V_ACTIVE(V), .X_INIT(0), .Y_INIT(0)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready1), .in_sof(in_sof),
    .in_eol(in_eol), .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_valid(out_valid1),
    .out_ready(out_ready), .out_raw(out_raw1), .out_x(out_x1), .out_y(out_y1),
    .out_sof(out_sof1), .out_eol(out_eol1), .frame_done(frame_done1), .err_line(err_line1));

  rgb_to_bayer_mosaic #(.DW(DW), .H_ACTIVE(H), .V_ACTIVE(V), .X_INIT(1), .Y_INIT(0)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready2), .in_sof(in_sof),
    .in_eol(in_eol), .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_valid(out_valid2),
    .out_ready(out_ready), .out_raw(out_raw2), .out_x(out_x2), .out_y(out_y2),
    .out_sof(out_sof2), .out_eol(out_eol2), .frame_done(frame_done2), .err_line(err_line2));

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: the expected contents of the output stage plus raster position.
  bit m_valid, m_x1, m_x2, m_y, m_sof, m_eol, m_fd, m_err, in_frame, started;
  int m_raw1, m_raw2, col, row;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bayer site from absolute raster position: even/even is R, odd/odd is B, otherwise G.
  function automatic int pick(input int c, input int r, input int rv, input int gv, input int bv);
    int site;
    site = 2 * (r % 2) + (c % 2);
    if (site == 0) return rv;
    if (site == 3) return bv;
    return gv;
  endfunction

  task automatic step(input bit v, input bit sof, input bit eol, input int r, input int g,
                      input int b, input bit ordy, input bit rst, output bit acc);
    bit exp_rdy, emit, line_bad, exp_err;
    int c, rr;
    @(negedge CLK);
    RST_N = !rst; in_valid = v; in_sof = sof; in_eol = eol; out_ready = ordy;
    in_r = r[DW-1:0]; in_g = g[DW-1:0]; in_b = b[DW-1:0];
    #1;
    exp_rdy = !m_valid || ordy;
    if (started) begin
      chk("in_ready1", {31'd0, in_ready1}, {31'd0, exp_rdy});
      chk("in_ready2", {31'd0, in_ready2}, {31'd0, exp_rdy});
    end
    acc = v && exp_rdy && !rst;
    if (rst) begin
      m_valid = 0; m_x1 = 0; m_x2 = 0; m_y = 0; m_sof = 0; m_eol = 0; m_fd = 0; m_err = 0;
      m_raw1 = 0; m_raw2 = 0; in_frame = 0; col = 0; row = 0;
    end else begin
      m_fd = 0;
      emit = acc && (sof || in_frame);
      if (!emit && m_valid && ordy) m_valid = 0;
      if (emit) begin
        c = sof ? 0 : col;
        rr = sof ? 0 : row;
        m_valid = 1; m_sof = sof; m_eol = eol;
        m_y = bit'(rr % 2); m_x1 = bit'(c % 2); m_x2 = bit'((c + 1) % 2);
        m_raw1 = pick(c, rr, r, g, b);
        m_raw2 = pick(c + 1, rr, r, g, b);
        line_bad = eol ? (c != H - 1) : (c == H - 1);
        if (sof) m_err = line_bad; else m_err = m_err | line_bad;
        if (eol) begin
          col = 0;
          if (rr == V - 1) begin m_fd = 1; row = 0; in_frame = 0; end
          else begin row = rr + 1; in_frame = 1; end
        end else begin
          col = (c < CMAX) ? c + 1 : CMAX;
          row = rr; in_frame = 1;
        end
      end
    end
`ifdef LINE_CHECK_EN
    exp_err = m_err;
`else
    exp_err = 1'b0;
`endif
    @(posedge CLK);
    #1;
    if (rst) started = 1;
    chk("out_valid1", {31'd0, out_valid1}, {31'd0, m_valid});
    chk("out_valid2", {31'd0, out_valid2}, {31'd0, m_valid});
    chk("out_raw1", {22'd0, out_raw1}, m_raw1);
    chk("out_raw2", {22'd0, out_raw2}, m_raw2);
    chk("out_x1", {31'd0, out_x1}, {31'd0, m_x1});
    chk("out_x2", {31'd0, out_x2}, {31'd0, m_x2});
    chk("out_y", {30'd0, out_y2, out_y1}, {30'd0, m_y, m_y});
    chk("out_sof", {30'd0, out_sof2, out_sof1}, {30'd0, m_sof, m_sof});
    chk("out_eol", {30'd0, out_eol2, out_eol1}, {30'd0, m_eol, m_eol});
    chk("frame_done", {30'd0, frame_done2, frame_done1}, {30'd0, m_fd, m_fd});
    chk("err_line", {30'd0, err_line2, err_line1}, {30'd0, exp_err, exp_err});
  endtask

  initial begin
    bit acc;
    int idx, guard;
    int q1[$], q2[$], qp[$];
    int e1[8] = '{100, 200, 100, 200, 200, 300, 200, 300};
    int e2[8] = '{200, 100, 200, 100, 300, 200, 300, 200};
    int ep[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    started = 0;

    // Reset held two cycles with in_valid high.
    step(1, 1, 0, 100, 200, 300, 1, 1, acc);
    step(1, 1, 0, 100, 200, 300, 1, 1, acc);
    chk("rst_in_ready", {31'd0, in_ready1}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);

    // Constant-colour 4x2 frame, no backpressure; log every output.
    for (int i = 0; i < 9; i++) begin
      step(i < 8, i == 0, (i % 4) == 3, 100, 200, 300, 1, 0, acc);
      if (out_valid1) begin
        q1.push_back(int'(out_raw1));
        q2.push_back(int'(out_raw2));
        qp.push_back(int'({out_y1, out_x1}));
      end
      if (i == 7) chk("t2_frame_done", {31'd0, frame_done1}, 32'd1);
    end
    chk("t2_count", q1.size(), 32'd8);
    for (int i = 0; i < 8 && i < q1.size(); i++) begin
      chk("t2_raw_x0", q1[i], e1[i]);
      chk("t2_raw_x1", q2[i], e2[i]);
      chk("t2_phase", qp[i], ep[i]);
    end

    // Same frame with out_ready toggling; pixels held until accepted.
    idx = 0; guard = 0;
    while (idx < 8 && guard < 40) begin
      step(1, idx == 0, (idx % 4) == 3, 100, 200, 300, (guard % 2) == 0, 0, acc);
      if (acc) idx++;
      guard++;
    end
    chk("t3_all_accepted", idx, 32'd8);
    step(0, 0, 0, 0, 0, 0, 1, 0, acc);

    // Pixels before sof are discarded; sof pixel lands on the R site.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 11, 22, 33, 1, 0, acc);
    chk("t4_nothing_out", {31'd0, out_valid1}, 32'd0);
    step(1, 1, 0, 100, 200, 300, 1, 0, acc);
    chk("t4_first_phase", {30'd0, out_y1, out_x1}, 32'd0);
    chk("t4_first_raw", {22'd0, out_raw1}, 32'd100);

    // Short line: eol on the third pixel, then the rest of the frame, then a fresh sof.
    step(1, 1, 0, 1, 2, 3, 1, 0, acc);
    step(1, 0, 0, 4, 5, 6, 1, 0, acc);
    step(1, 0, 1, 7, 8, 9, 1, 0, acc);
    for (int i = 0; i < 4; i++) step(1, 0, i == 3, 10, 20, 30, 1, 0, acc);
    step(1, 1, 0, 40, 50, 60, 1, 0, acc);

    // Runaway line: column saturates instead of wrapping.
    for (int i = 0; i < 11; i++) step(1, i == 0, 0, 100 + i, 200 + i, 300 + i, 1, 0, acc);
    step(1, 0, 1, 5, 6, 7, 1, 0, acc);

    // Mid-frame reset drops the frame; following non-sof pixels are discarded.
    step(1, 1, 0, 9, 8, 7, 1, 0, acc);
    step(1, 0, 0, 9, 8, 7, 0, 0, acc);
    step(1, 0, 0, 9, 8, 7, 0, 1, acc);
    step(1, 0, 0, 9, 8, 7, 1, 0, acc);
    step(1, 0, 1, 9, 8, 7, 1, 0, acc);

    // Random traffic with random backpressure and framing.
    for (int i = 0; i < 500; i++) begin
      step(($urandom % 4) != 0, ($urandom % 12) == 0, ($urandom % 4) == 0,
           int'($urandom % 1024), int'($urandom % 1024), int'($urandom % 1024),
           ($urandom % 3) != 0, ($urandom % 200) == 0, acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
